// File: rtl/alu_mc_if.sv
// Request/response bundle between the controller side and alu_mc.
// The master drives operands and the opcode; the slave returns results and flags.
interface alu_mc_if #(
    parameter int WIDTH      = 8,
    parameter int FUNC_WIDTH = 4
);
    logic                  i_valid;
    logic [WIDTH-1:0]      i_a;
    logic [WIDTH-1:0]      i_b;
    logic [FUNC_WIDTH-1:0] i_func;
    logic                  o_ready;
    logic                  o_valid;
    logic [WIDTH-1:0]      o_result;
    logic [WIDTH-1:0]      o_rem;
    logic                  o_carry;
    logic                  o_zero;
    logic                  o_div0;

    modport master (
        output i_valid, i_a, i_b, i_func,
        input  o_ready, o_valid, o_result, o_rem, o_carry, o_zero, o_div0
    );

    modport slave (
        input  i_valid, i_a, i_b, i_func,
        output o_ready, o_valid, o_result, o_rem, o_carry, o_zero, o_div0
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus an iterative
// restoring divider that occupies the unit for WIDTH cycles.
module alu_mc #(
    parameter int WIDTH      = 8,
    parameter int FUNC_WIDTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    alu_mc_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [FUNC_WIDTH-1:0] FN_ADD  = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] FN_SUB  = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] FN_MUL  = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] FN_DIV  = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] FN_AND  = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] FN_OR   = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] FN_NAND = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] FN_NOR  = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] FN_XOR  = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] FN_XNOR = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] FN_EQ   = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] FN_GT   = FUNC_WIDTH'(11);
    localparam logic [FUNC_WIDTH-1:0] FN_SHR  = FUNC_WIDTH'(12);
    localparam logic [FUNC_WIDTH-1:0] FN_SHL  = FUNC_WIDTH'(13);

    typedef enum logic {IDLE, DIV} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               vld_p1;
    logic [WIDTH-1:0]   result_p1;
    logic [WIDTH-1:0]   rem_p1;
    logic               carry_p1;
    logic               zero_p1;
    logic               div0_p1;

    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   rem_acc;
    logic [WIDTH-1:0]   quo;

    logic               accept;
    logic               div_start;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   alu_rem;
    logic               alu_carry;
    logic               alu_div0;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign bus.o_ready  = (state == IDLE);
    assign bus.o_valid  = vld_p1;
    assign bus.o_result = result_p1;
    assign bus.o_rem    = rem_p1;
    assign bus.o_carry  = carry_p1;
    assign bus.o_zero   = zero_p1;
    assign bus.o_div0   = div0_p1;

    assign accept    = bus.i_valid && (state == IDLE);
    assign div_start = (bus.i_func == FN_DIV) && (bus.i_b != '0);

    always_comb begin
        alu_res   = '0;
        alu_rem   = '0;
        alu_carry = 1'b0;
        alu_div0  = 1'b0;
        sum  = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        prod = (2*WIDTH)'(bus.i_a) * (2*WIDTH)'(bus.i_b);
        case (bus.i_func)
            FN_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            FN_SUB: begin
                alu_res   = bus.i_a - bus.i_b;
                alu_carry = (bus.i_a < bus.i_b);
            end
            FN_MUL: begin
                alu_res   = prod[WIDTH-1:0];
                alu_carry = (prod[2*WIDTH-1:WIDTH] != '0);
            end
            // Only the divide-by-zero case completes here; other divides iterate.
            FN_DIV: begin
                if (bus.i_b == '0) begin
                    alu_res  = '1;
                    alu_rem  = bus.i_a;
                    alu_div0 = 1'b1;
                end
            end
            FN_AND:  alu_res = bus.i_a & bus.i_b;
            FN_OR:   alu_res = bus.i_a | bus.i_b;
            FN_NAND: alu_res = ~(bus.i_a & bus.i_b);
            FN_NOR:  alu_res = ~(bus.i_a | bus.i_b);
            FN_XOR:  alu_res = bus.i_a ^ bus.i_b;
            FN_XNOR: alu_res = ~(bus.i_a ^ bus.i_b);
            FN_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.i_a == bus.i_b)};
            FN_GT:   alu_res = {{(WIDTH-1){1'b0}}, (bus.i_a > bus.i_b)};
            FN_SHR: begin
                alu_res   = bus.i_a >> 1;
                alu_carry = bus.i_a[0];
            end
            FN_SHL: begin
                alu_res   = bus.i_a << 1;
                alu_carry = bus.i_a[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Restoring step: the sign bit of the trial subtraction selects the quotient bit.
    always_comb begin
        shifted  = {rem_acc, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], qbit};
    end

    // Divider working registers carry data only and need no reset.
    always_ff @(posedge i_clk) begin
        if (accept && div_start) begin
            dvd     <= bus.i_a;
            dvs     <= bus.i_b;
            rem_acc <= '0;
            quo     <= '0;
        end else if (state == DIV) begin
            dvd     <= dvd << 1;
            rem_acc <= rem_next;
            quo     <= quo_next;
        end
    end

    // ---- stage p1: control FSM and registered outputs ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            rem_p1    <= '0;
            carry_p1  <= 1'b0;
            zero_p1   <= 1'b0;
            div0_p1   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_start) begin
                            cnt   <= '0;
                            state <= DIV;
                        end else begin
                            vld_p1    <= 1'b1;
                            result_p1 <= alu_res;
                            rem_p1    <= alu_rem;
                            carry_p1  <= alu_carry;
                            zero_p1   <= (alu_res == '0);
                            div0_p1   <= alu_div0;
                        end
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        vld_p1    <= 1'b1;
                        result_p1 <= quo_next;
                        rem_p1    <= rem_next;
                        carry_p1  <= 1'b0;
                        zero_p1   <= (quo_next == '0);
                        div0_p1   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed and random bench for alu_mc at WIDTH = 16 with a result scoreboard.
module tb_alu_mc;
    localparam int W  = 16;
    localparam int FW = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         carry;
        logic         zero;
        logic         div0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];

    alu_mc_if #(.WIDTH(W), .FUNC_WIDTH(FW)) bus ();

    alu_mc #(.WIDTH(W), .FUNC_WIDTH(FW)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [FW-1:0] f);
        exp_t e;
        logic [31:0] p;
        logic [W:0] s;
        e = '0;
        p = {16'h0, a} * {16'h0, b};
        s = {1'b0, a} + {1'b0, b};
        case (f)
            4'd0:  begin e.res = s[W-1:0]; e.carry = s[W]; end
            4'd1:  begin e.res = a - b; e.carry = (a < b); end
            4'd2:  begin e.res = p[W-1:0]; e.carry = (p[31:16] != 16'h0); end
            4'd3:  begin
                if (b == 0) begin e.res = '1; e.rem = a; e.div0 = 1'b1; end
                else begin e.res = a / b; e.rem = a % b; end
            end
            4'd4:  e.res = a & b;
            4'd5:  e.res = a | b;
            4'd6:  e.res = ~(a & b);
            4'd7:  e.res = ~(a | b);
            4'd8:  e.res = a ^ b;
            4'd9:  e.res = ~(a ^ b);
            4'd10: e.res = (a == b) ? 16'd1 : 16'd0;
            4'd11: e.res = (a > b) ? 16'd1 : 16'd0;
            4'd12: begin e.res = {1'b0, a[W-1:1]}; e.carry = a[0]; end
            4'd13: begin e.res = {a[W-2:0], 1'b0}; e.carry = a[W-1]; end
            default: ;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Scoreboard consumer: every o_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'(bus.o_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", 32'(bus.o_result), 32'(e.res));
                check("rem",    32'(bus.o_rem),    32'(e.rem));
                check("carry",  32'(bus.o_carry),  32'(e.carry));
                check("zero",   32'(bus.o_zero),   32'(e.zero));
                check("div0",   32'(bus.o_div0),   32'(e.div0));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [FW-1:0] f);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_func = f;
        bus.i_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) begin
                sbq.push_back(model(a, b, f));
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    check("ready_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        bus.i_valid = 1'b0;
    endtask

    initial begin
        int low;
        logic [W-1:0] ra, rb;
        logic [FW-1:0] rf;

        bus.i_valid = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_func = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(bus.o_ready),  32'd1);
        check("rst_valid",  32'(bus.o_valid),  32'd0);
        check("rst_result", 32'(bus.o_result), 32'd0);
        check("rst_rem",    32'(bus.o_rem),    32'd0);
        check("rst_flags",  32'({bus.o_carry, bus.o_zero, bus.o_div0}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD overflow to zero
        issue(16'hFFFF, 16'h0001, 4'd0);

        // Back-to-back SUB, MUL, SHL
        issue(16'd5, 16'd7, 4'd1);
        issue(16'h0100, 16'h0100, 4'd2);
        issue(16'h8001, 16'h0000, 4'd13);
        repeat (3) @(posedge clk);
        #1;

        // DIV 100/7 with a request dropped while busy
        bus.i_a = 16'd100;
        bus.i_b = 16'd7;
        bus.i_func = 4'd3;
        bus.i_valid = 1'b1;
        @(negedge clk);
        check("div_ready_before", 32'(bus.o_ready), 32'd1);
        sbq.push_back(model(16'd100, 16'd7, 4'd3));
        @(posedge clk);
        #1;
        bus.i_a = 16'd1;
        bus.i_b = 16'd1;
        bus.i_func = 4'd0;
        low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            low++;
        end
        bus.i_valid = 1'b0;
        check("div_ready_low_cycles", 32'(low), 32'd16);
        check("div_valid_with_ready", 32'(bus.o_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Divide by zero completes in one cycle
        issue(16'd9, 16'd0, 4'd3);
        @(negedge clk);
        check("div0_ready", 32'(bus.o_ready), 32'd1);
        check("div0_valid", 32'(bus.o_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a divide discards the result
        issue(16'd1000, 16'd3, 4'd3);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("midrst_ready",  32'(bus.o_ready),  32'd1);
        check("midrst_valid",  32'(bus.o_valid),  32'd0);
        check("midrst_result", 32'(bus.o_result), 32'd0);
        check("midrst_rem",    32'(bus.o_rem),    32'd0);
        check("midrst_flags",  32'({bus.o_carry, bus.o_zero, bus.o_div0}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        issue(16'd2, 16'd3, 4'd0);
        repeat (2) @(posedge clk);
        #1;

        // Random operations, including reserved opcodes and zero divisors
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rf = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: rb = 16'd0;
                1: rb = ra;
                2: rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            issue(ra, rb, rf);
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (25) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
